// File: rtl/button_conditioner_if.sv
// Signal bundle between the raw push-button pin and its conditioned outputs.
// The conditioner takes the slave side; board/user logic takes the master side.
interface button_conditioner_if;
   logic btn_raw;
   logic btn_level;
   logic btn_press;
   logic btn_release;
   logic rst_req;

   modport master (
      output btn_raw,
      input  btn_level,
      input  btn_press,
      input  btn_release,
      input  rst_req
   );

   modport slave (
      input  btn_raw,
      output btn_level,
      output btn_press,
      output btn_release,
      output rst_req
   );
endinterface

// File: rtl/button_conditioner.sv
// Push-button front end: synchroniser, debouncer, press/release strobes, long-press reset request.
// Define BUTTON_AUTOREPEAT_EN to add periodic extra btn_press strobes while the button is held.
module button_conditioner #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEBOUNCE    = 50000,
   parameter int unsigned LONG_PRESS  = 12000000,
   parameter int unsigned RST_PULSE   = 16,
   parameter int unsigned REPEAT      = 3000000
) (
   input logic                 CLK,
   input logic                 RESET,
   button_conditioner_if.slave btn
);

   localparam int unsigned DEB_W  = $clog2(DEBOUNCE + 1);
   localparam int unsigned HOLD_W = $clog2(LONG_PRESS + 1);
   localparam int unsigned RST_W  = $clog2(RST_PULSE + 1);

   localparam logic [DEB_W-1:0]  DEB_ONE  = DEB_W'(1);
   localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS);
   localparam logic [RST_W-1:0]  RST_MAX  = RST_W'(RST_PULSE);

   localparam logic [1:0] IDLE         = 2'd0;
   localparam logic [1:0] PRESS_WAIT   = 2'd1;
   localparam logic [1:0] HELD         = 2'd2;
   localparam logic [1:0] RELEASE_WAIT = 2'd3;

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
   end
   if (DEBOUNCE < 1 || LONG_PRESS < 1 || RST_PULSE < 1 || REPEAT < 1) begin : g_bad_count
      $error("DEBOUNCE, LONG_PRESS, RST_PULSE and REPEAT must be at least 1");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   btn_s;

   logic [1:0]        state_q, state_d;
   logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
   logic              rst_fired_q, rst_fired_d;
   logic              level_q, level_d;
   logic              press_q, press_d;
   logic              release_q, release_d;
   logic              rst_req_q, rst_req_d;
   logic              accept_press;
   logic              fire;
   logic              rep_fire;

   // Metastability chain; only the last stage is ever looked at.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn.btn_raw};
      end
   end

   assign btn_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d      = state_q;
      deb_cnt_d    = deb_cnt_q;
      hold_cnt_d   = hold_cnt_q;
      rst_fired_d  = rst_fired_q;
      level_d      = level_q;
      release_d    = 1'b0;
      accept_press = 1'b0;
      fire         = 1'b0;

      case (state_q)
         IDLE: begin
            if (btn_s) begin
               state_d   = PRESS_WAIT;
               deb_cnt_d = DEB_ONE;
            end
         end
         PRESS_WAIT: begin
            if (!btn_s) begin
               state_d = IDLE;
            end else if (deb_cnt_q == DEB_MAX) begin
               state_d      = HELD;
               level_d      = 1'b1;
               accept_press = 1'b1;
               hold_cnt_d   = '0;
               rst_fired_d  = 1'b0;
            end else begin
               deb_cnt_d = deb_cnt_q + DEB_ONE;
            end
         end
         HELD: begin
            if (!btn_s) begin
               state_d   = RELEASE_WAIT;
               deb_cnt_d = DEB_ONE;
            end else if (hold_cnt_q != HOLD_MAX) begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
               // Fires once on the cycle the hold time is reached; saturation keeps it there.
               if (hold_cnt_d == HOLD_MAX && !rst_fired_q) begin
                  fire        = 1'b1;
                  rst_fired_d = 1'b1;
               end
            end
         end
         RELEASE_WAIT: begin
            // Bounce back to HELD keeps hold_cnt so long-press timing is not restarted.
            if (btn_s) begin
               state_d = HELD;
            end else if (deb_cnt_q == DEB_MAX) begin
               state_d   = IDLE;
               level_d   = 1'b0;
               release_d = 1'b1;
            end else begin
               deb_cnt_d = deb_cnt_q + DEB_ONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef BUTTON_AUTOREPEAT_EN
   localparam int unsigned REP_W = $clog2(REPEAT + 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT - 1);

   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

   // Runs through HELD and RELEASE_WAIT; stops on the cycle that returns to IDLE.
   always_comb begin
      rep_cnt_d = rep_cnt_q;
      rep_fire  = 1'b0;
      if (state_q == PRESS_WAIT) begin
         rep_cnt_d = '0;
      end else if ((state_q == HELD || state_q == RELEASE_WAIT) && state_d != IDLE) begin
         if (rep_cnt_q == REP_LAST) begin
            rep_cnt_d = '0;
            rep_fire  = 1'b1;
         end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rep_cnt_q <= '0;
      end else begin
         rep_cnt_q <= rep_cnt_d;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   assign press_d = accept_press | rep_fire;

   // Pulse width is counted independently of the button so a release cannot shorten it.
   always_comb begin
      rst_cnt_d = rst_cnt_q;
      if (fire) begin
         rst_cnt_d = RST_MAX;
      end else if (rst_cnt_q != '0) begin
         rst_cnt_d = rst_cnt_q - RST_W'(1);
      end
      rst_req_d = (rst_cnt_d != '0);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= IDLE;
         deb_cnt_q   <= '0;
         hold_cnt_q  <= '0;
         rst_cnt_q   <= '0;
         rst_fired_q <= 1'b0;
         level_q     <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         rst_req_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         deb_cnt_q   <= deb_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         rst_cnt_q   <= rst_cnt_d;
         rst_fired_q <= rst_fired_d;
         level_q     <= level_d;
         press_q     <= press_d;
         release_q   <= release_d;
         rst_req_q   <= rst_req_d;
      end
   end

   assign btn.btn_level   = level_q;
   assign btn.btn_press   = press_q;
   assign btn.btn_release = release_q;
   assign btn.rst_req     = rst_req_q;

   a_press_release_exclusive : assert property (
      @(posedge CLK) disable iff (RESET) !(press_q && release_q)
   );

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: run-length behavioural model plus directed timing checks.
// Works with or without BUTTON_AUTOREPEAT_EN defined.
module tb_button_conditioner;

   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned DEBOUNCE    = 4;
   localparam int unsigned LONG_PRESS  = 20;
   localparam int unsigned RST_PULSE   = 3;
   localparam int unsigned REPEAT      = 8;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;

   button_conditioner_if bif ();

   button_conditioner #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE    (DEBOUNCE),
      .LONG_PRESS  (LONG_PRESS),
      .RST_PULSE   (RST_PULSE),
      .REPEAT      (REPEAT)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .btn   (bif)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   int   cyc;
   logic d1, d2, last_s;
   int   run;
   logic m_level, m_press, m_rel, m_rst;
   int   hold;
   bit   fired, any_fire;
   int   fire_cyc, press_cyc;

   // Strobe counters observed on the DUT
   int   press_cnt = 0, rel_cnt = 0, rst_rises = 0;
   logic rst_prev  = 1'b0;

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      d1 = 0; d2 = 0; last_s = 0; run = 0;
      m_level = 0; m_press = 0; m_rel = 0; m_rst = 0;
      hold = 0; fired = 0; any_fire = 0; fire_cyc = 0; press_cyc = 0;
   endtask

   // The level flips once DEBOUNCE+1 consecutive synchronised samples disagree with it.
   task automatic model_step();
      logic s;
      logic held_before;
      s  = d2;
      d2 = d1;
      d1 = bif.btn_raw;
      held_before = m_level && last_s;
      run = (s == last_s) ? run + 1 : 1;
      m_press = 0;
      m_rel   = 0;
      if (!m_level && s && run > int'(DEBOUNCE)) begin
         m_level = 1; m_press = 1; hold = 0; fired = 0; press_cyc = cyc;
      end else if (m_level && !s && run > int'(DEBOUNCE)) begin
         m_level = 0; m_rel = 1;
      end else if (held_before && s && hold < int'(LONG_PRESS)) begin
         hold++;
         if (hold == int'(LONG_PRESS) && !fired) begin
            fired = 1; any_fire = 1; fire_cyc = cyc;
         end
      end
`ifdef BUTTON_AUTOREPEAT_EN
      if (m_level && !m_press && ((cyc - press_cyc) % int'(REPEAT)) == 0) m_press = 1;
`endif
      m_rst  = any_fire && ((cyc - fire_cyc) < int'(RST_PULSE));
      last_s = s;
   endtask

   initial begin
      cyc = 0;
      model_reset();
      forever begin
         @(posedge CLK or posedge RESET);
         if (RESET) begin
            model_reset();
         end else begin
            cyc++;
            model_step();
         end
      end
   end

   // Per-cycle comparison against the model, sampled away from the active edge.
   initial begin
      forever begin
         @(negedge CLK);
         check_bit("model_level",   bif.btn_level,   m_level);
         check_bit("model_press",   bif.btn_press,   m_press);
         check_bit("model_release", bif.btn_release, m_rel);
         check_bit("model_rst_req", bif.rst_req,     m_rst);
         if (bif.btn_press === 1'b1) press_cnt++;
         if (bif.btn_release === 1'b1) rel_cnt++;
         if (bif.rst_req === 1'b1 && rst_prev === 1'b0) rst_rises++;
         rst_prev = bif.rst_req;
      end
   end

   function automatic logic sig(input int which);
      case (which)
         0:       return bif.btn_press;
         1:       return bif.btn_release;
         default: return bif.rst_req;
      endcase
   endfunction

   // Counts rising edges until the selected output is seen high at a negedge.
   task automatic wait_for(input int which, input string name, output int n);
      n = 0;
      while (n < 200) begin
         @(posedge CLK);
         n++;
         @(negedge CLK);
         if (sig(which) === 1'b1) return;
      end
      checks++;
      errors++;
      $display("FAIL %s: timeout, got no strobe within %0d cycles", name, n);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge CLK);
   endtask

   int n, p0, r0, k, rst_k, rst_high, rep_cnt;

   initial begin
      bif.btn_raw = 1'b0;
      idle_cycles(3);
      check_bit("reset_level",   bif.btn_level,   1'b0);
      check_bit("reset_press",   bif.btn_press,   1'b0);
      check_bit("reset_release", bif.btn_release, 1'b0);
      check_bit("reset_rst_req", bif.rst_req,     1'b0);
      RESET = 1'b0;
      idle_cycles(4);

      // Glitch: three raw-high cycles are too short to be accepted.
      p0 = press_cnt;
      bif.btn_raw = 1'b1;
      idle_cycles(3);
      bif.btn_raw = 1'b0;
      idle_cycles(12);
      check_int("glitch_no_press", press_cnt - p0, 0);
      check_bit("glitch_level", bif.btn_level, 1'b0);

      // Clean press: strobe 6 cycles after the first sampling edge (7th edge counted here).
      bif.btn_raw = 1'b1;
      wait_for(0, "press_latency", n);
      check_int("press_latency", n, 7);
      check_bit("press_level", bif.btn_level, 1'b1);

      // Release bounce 0,1,0 then low: one release, 6 cycles after the final falling edge.
      idle_cycles(3);
      r0 = rel_cnt;
      bif.btn_raw = 1'b0;
      @(negedge CLK) bif.btn_raw = 1'b1;
      @(negedge CLK) bif.btn_raw = 1'b0;
      wait_for(1, "release_latency", n);
      check_int("release_latency", n, 7);
      idle_cycles(20);
      check_int("release_once", rel_cnt - r0, 1);
      check_bit("release_level", bif.btn_level, 1'b0);

      // Long press held 40 cycles: rst_req 20 cycles after press, 3 cycles wide, once.
      r0 = rst_rises;
      bif.btn_raw = 1'b1;
      wait_for(0, "long_press_latency", n);
      check_int("long_press_latency", n, 7);
      rst_k = -1; rst_high = 0; rep_cnt = 0;
      for (k = 1; k <= 34; k++) begin
         @(negedge CLK);
         if (bif.rst_req === 1'b1) begin
            rst_high++;
            if (rst_k < 0) rst_k = k;
         end
         if (k <= 30 && bif.btn_press === 1'b1) rep_cnt++;
      end
      check_int("rst_req_start", rst_k, 20);
      check_int("rst_req_width", rst_high, 3);
`ifdef BUTTON_AUTOREPEAT_EN
      check_int("autorepeat_count", rep_cnt, 3);
`else
      check_int("no_extra_press", rep_cnt, 0);
`endif
      bif.btn_raw = 1'b0;
      p0 = press_cnt;
      idle_cycles(30);
      check_int("rst_req_once", rst_rises - r0, 1);
      check_int("no_press_after_release", press_cnt - p0, 0);

      // Reset during the pulse clears outputs at once; re-press follows a fresh debounce.
      bif.btn_raw = 1'b1;
      wait_for(0, "pre_reset_press", n);
      wait_for(2, "pre_reset_rst_req", n);
      #2 RESET = 1'b1;
      #1;
      check_bit("midreset_level",   bif.btn_level,   1'b0);
      check_bit("midreset_press",   bif.btn_press,   1'b0);
      check_bit("midreset_release", bif.btn_release, 1'b0);
      check_bit("midreset_rst_req", bif.rst_req,     1'b0);
      @(negedge CLK) RESET = 1'b0;
      wait_for(0, "post_reset_press", n);
      check_int("post_reset_press", n, 7);
      bif.btn_raw = 1'b0;
      idle_cycles(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
